// File: rtl/tree_pkg.sv
// Control types for the node_tree arbitration front end.
package tree_pkg;
  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;
endpackage

// File: rtl/user_tree_pkg.sv
// Shared node_tree data types: field identifiers and the node record
// returned by the lookup engine.
package user_tree_pkg;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned NODE_W = 32;

  typedef logic [ID_W-1:0]   identifier;
  typedef logic [NODE_W-1:0] node_data;
endpackage

// File: rtl/node_tree_arb_rr_arbiter.sv
// Round-robin pick: first requester after last_grant (cyclically) with
// its request bit set.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any
);

  int unsigned idx;

  always_comb begin
    grant = last_grant;
    any   = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_grant) + k) % N;
      if (!any && req[IW'(idx)]) begin
        any   = 1'b1;
        grant = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/node_tree_arb.sv
// Shares one node_tree lookup engine between NUM_REQ requesters; a grant is
// held for a whole message and at most one lookup is in flight.
module node_tree_arb
  import user_tree_pkg::*;
  import tree_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0][ID_W-1:0]  req_field_id,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [NODE_W-1:0]             rsp_node,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_rdy,
  output logic [ID_W-1:0]               lk_field_id,
  output logic                          lk_valid,
  input  logic                          lk_rdy,
  input  logic [NODE_W-1:0]             lk_node,
  input  logic                          lk_node_valid,
  output logic                          lk_node_rdy,
  output logic                          lk_restart,
  output logic                          timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t      state;
  logic [IW-1:0]   g;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   pick;
  logic            any;
  logic            last_q;
  logic [CW-1:0]   cnt;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .any        (any)
  );

  // Field-id channel is a pass-through of the granted requester while issuing.
  always_comb begin
    req_rdy     = '0;
    lk_valid    = 1'b0;
    lk_field_id = req_field_id[g];
    if (state == ISSUE) begin
      lk_valid   = req_valid[g];
      req_rdy[g] = lk_rdy;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      last_grant  <= IW'(NUM_REQ - 1);
      g           <= '0;
      last_q      <= 1'b0;
      cnt         <= '0;
      rsp_node    <= '0;
      rsp_valid   <= '0;
      lk_node_rdy <= 1'b0;
      lk_restart  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      lk_restart  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            g          <= pick;
            lk_restart <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: state <= ISSUE;
        ISSUE: begin
          if (lk_valid && lk_rdy) begin
            last_q      <= req_last[g];
            cnt         <= '0;
            lk_node_rdy <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the final counted cycle still wins over the timeout.
          if (lk_node_valid) begin
            rsp_node    <= lk_node;
            rsp_valid   <= NUM_REQ'(1) << g;
            lk_node_rdy <= 1'b0;
            state       <= RESP;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            lk_node_rdy <= 1'b0;
            last_grant  <= g;
            state       <= IDLE;
          end else if (cnt != CW'(TIMEOUT_CYCLES)) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_rdy[g]) begin
            rsp_valid <= '0;
            if (last_q) begin
              last_grant <= g;
              state      <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_node_tree_arb.sv
// Self-checking bench for node_tree_arb: requester/engine models driven at
// the falling edge, message-level reference model checking grants and data.
module tb_node_tree_arb;
  import user_tree_pkg::*;
  import tree_pkg::*;

  localparam int NR = 4;
  localparam int TMO = 255;

  typedef struct packed {
    logic [7:0] id;
    logic       last;
  } fld_t;

  typedef struct {
    logic [NR-1:0] mask;
    logic [7:0]    id;
    int            exp_grant;
    node_data      exp_node;
  } vec_t;

  logic                  clk;
  logic                  rst_n;
  logic [NR-1:0][7:0]    req_field_id;
  logic [NR-1:0]         req_last, req_valid, req_rdy;
  node_data              rsp_node;
  logic [NR-1:0]         rsp_valid, rsp_rdy;
  logic [7:0]            lk_field_id;
  logic                  lk_valid, lk_rdy;
  node_data              lk_node;
  logic                  lk_node_valid, lk_node_rdy, lk_restart, timeout_err;

  node_tree_arb #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst_n),
    .req_field_id  (req_field_id),
    .req_last      (req_last),
    .req_valid     (req_valid),
    .req_rdy       (req_rdy),
    .rsp_node      (rsp_node),
    .rsp_valid     (rsp_valid),
    .rsp_rdy       (rsp_rdy),
    .lk_field_id   (lk_field_id),
    .lk_valid      (lk_valid),
    .lk_rdy        (lk_rdy),
    .lk_node       (lk_node),
    .lk_node_valid (lk_node_valid),
    .lk_node_rdy   (lk_node_rdy),
    .lk_restart    (lk_restart),
    .timeout_err   (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  fld_t     rq[NR][$];
  node_data exp_rsp[NR][$];
  node_data last_rsp[NR];
  int       rsp_cnt[NR];
  int       grant_log[$];
  int       owner, prev, last_issuer;
  int       restarts, issues, tmo_seen;
  bit       eng_busy, eng_mute, junk_en, rsp_hold;
  logic [7:0] eng_id;
  int       eng_wait;
  int       lkrdy_pct, rsprdy_pct, gap_pct, dmin, dmax;

  function automatic node_data node_of(input logic [7:0] id);
    return {id, ~id, id ^ 8'h5A, id + 8'd1};
  endfunction

  function automatic int pending_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += exp_rsp[i].size();
    return s;
  endfunction

  function automatic int rr_next();
    for (int k = 1; k <= NR; k++)
      if (rq[(prev + k) % NR].size() > 0) return (prev + k) % NR;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_knobs(input int lkr, input int rspr, input int gap,
                           input int dlo, input int dhi, input bit junk);
    lkrdy_pct = lkr; rsprdy_pct = rspr; gap_pct = gap;
    dmin = dlo; dmax = dhi; junk_en = junk;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      exp_rsp[i].delete();
      rsp_cnt[i] = 0;
      last_rsp[i] = '0;
    end
    grant_log.delete();
    owner = -1; prev = NR - 1; last_issuer = 0;
    restarts = 0; issues = 0; tmo_seen = 0;
    eng_busy = 0; eng_mute = 0; rsp_hold = 0; eng_wait = 0; eng_id = '0;
    req_valid = '0; req_last = '0; req_field_id = '0;
    rsp_rdy = '0; lk_rdy = 1'b0; lk_node_valid = 1'b0; lk_node = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_node", rsp_node, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_ctl", {lk_valid, lk_node_rdy, lk_restart, timeout_err}, 0);
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_state", 64'(dut.state), 64'(IDLE));
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0 && !(owner == i && $urandom_range(99) < gap_pct)) begin
        req_valid[i]    = 1'b1;
        req_field_id[i] = rq[i][0].id;
        req_last[i]     = rq[i][0].last;
      end else begin
        req_valid[i]    = 1'b0;
        req_field_id[i] = 8'($urandom);
        req_last[i]     = 1'($urandom);
      end
      rsp_rdy[i] = !rsp_hold && ($urandom_range(99) < rsprdy_pct);
    end
    lk_rdy = ($urandom_range(99) < lkrdy_pct);
    if (eng_busy) lk_node_valid = (eng_wait == 0);
    else          lk_node_valid = junk_en && ($urandom_range(99) < 20);
    lk_node = (eng_busy && lk_node_valid) ? node_of(eng_id) : node_data'($urandom);
  endtask

  // Evaluates what the next rising edge will see; all values are settled here.
  task automatic observe();
    int   who, ew;
    fld_t f;
    if (!rst_n) return;
    if (lk_restart) restarts++;
    if (timeout_err) begin
      tmo_seen++;
      if (exp_rsp[last_issuer].size() > 0) void'(exp_rsp[last_issuer].pop_back());
      owner = -1; prev = last_issuer; eng_busy = 0;
    end
    check("rdy_onehot", $onehot0(req_rdy), 1);
    check("rsp_onehot", $onehot0(rsp_valid), 1);
    if (owner != -1) check("rdy_exclusive", req_rdy & ~(NR'(1) << owner), 0);
    if (lk_valid && lk_rdy) begin
      issues++;
      who = -1;
      for (int i = 0; i < NR; i++) if (req_rdy[i]) who = i;
      check("one_outstanding", pending_total(), 0);
      ew = (owner == -1) ? rr_next() : owner;
      check("grant_idx", 64'(who), 64'(ew));
      if (who >= 0 && rq[who].size() > 0) begin
        check("lk_field_id", lk_field_id, rq[who][0].id);
        if (owner == -1) grant_log.push_back(who);
        owner = who;
        f = rq[who].pop_front();
        exp_rsp[who].push_back(node_of(f.id));
        last_issuer = who;
        if (f.last) begin owner = -1; prev = who; end
      end
      eng_busy = !eng_mute;
      eng_id   = lk_field_id;
      eng_wait = $urandom_range(dmax, dmin);
    end else if (lk_node_valid && lk_node_rdy) begin
      check("node_accept_in_wait", eng_busy, 1);
      eng_busy = 0;
    end else if (eng_busy && eng_wait > 0) begin
      eng_wait--;
    end
    for (int i = 0; i < NR; i++) begin
      if (rsp_valid[i] && rsp_rdy[i]) begin
        check("rsp_expected", exp_rsp[i].size() > 0, 1);
        if (exp_rsp[i].size() > 0) check("rsp_node", rsp_node, exp_rsp[i].pop_front());
        last_rsp[i] = rsp_node;
        rsp_cnt[i]++;
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    drive();
    #1;
    observe();
  endtask

  task automatic run_until_idle(input int maxc);
    int  n = 0;
    bool_loop: while (n < maxc) begin
      bit busy = 0;
      for (int i = 0; i < NR; i++) if (rq[i].size() > 0) busy = 1;
      if (!busy && pending_total() == 0 && !eng_busy && owner == -1) break;
      run_cycle();
      n++;
    end
    if (n >= maxc) check("drain_bound", 0, 1);
    repeat (3) run_cycle();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   exp_order[5];
    int   n, g0, seen, nfields, tot;
    bit   stable, quiet;
    node_data v;

    rst_n = 1'b0;
    set_knobs(100, 100, 0, 0, 1, 0);
    clear_model();
    repeat (2) @(negedge clk);
    do_reset();

    // Single-field arbitration vectors, applied back to back from reset.
    tbl[0] = '{4'b0010, 8'h10, 1, node_of(8'h11)};
    tbl[1] = '{4'b1111, 8'h20, 2, node_of(8'h22)};
    tbl[2] = '{4'b1011, 8'h30, 3, node_of(8'h33)};
    tbl[3] = '{4'b0011, 8'h40, 0, node_of(8'h40)};
    tbl[4] = '{4'b1001, 8'h50, 3, node_of(8'h53)};
    tbl[5] = '{4'b0001, 8'h60, 0, node_of(8'h60)};
    tbl[6] = '{4'b0110, 8'h70, 1, node_of(8'h71)};
    tbl[7] = '{4'b0100, 8'h80, 2, node_of(8'h82)};
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < NR; j++)
        if (tbl[t].mask[j]) rq[j].push_back('{id: tbl[t].id + 8'(j), last: 1'b1});
      n = grant_log.size();
      for (int c = 0; c < 50 && grant_log.size() == n; c++) run_cycle();
      g0 = (grant_log.size() > n) ? grant_log[n] : -1;
      for (int j = 0; j < NR; j++) if (j != g0) rq[j].delete();
      run_until_idle(100);
      check("tbl_grant", 64'(g0), 64'(tbl[t].exp_grant));
      check("tbl_node", last_rsp[tbl[t].exp_grant], tbl[t].exp_node);
    end

    // Two-field message from requester 1.
    do_reset();
    rq[1].push_back('{id: 8'd3, last: 1'b0});
    rq[1].push_back('{id: 8'd5, last: 1'b1});
    set_knobs(100, 100, 0, 0, 2, 1);
    run_until_idle(100);
    check("msg_restarts", restarts, 1);
    check("msg_lookups", issues, 2);
    check("msg_rsp_cnt", rsp_cnt[1], 2);
    check("msg_idle", 64'(dut.state), 64'(IDLE));

    // All requesters continuously requesting single-field messages.
    do_reset();
    set_knobs(100, 100, 0, 0, 0, 0);
    for (int m = 0; m < 2; m++)
      for (int j = 0; j < NR; j++) rq[j].push_back('{id: 8'(16 * m + j), last: 1'b1});
    run_until_idle(300);
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_count", grant_log.size(), 8);
    for (int k = 0; k < 5; k++)
      check("rr_order", 64'((grant_log.size() > k) ? grant_log[k] : -1), 64'(exp_order[k]));

    // Requester 2 must wait until requester 0's whole message is answered.
    do_reset();
    set_knobs(70, 40, 30, 1, 4, 1);
    rq[0].push_back('{id: 8'd10, last: 1'b0});
    rq[0].push_back('{id: 8'd11, last: 1'b1});
    for (int c = 0; c < 50 && owner != 0; c++) run_cycle();
    rq[2].push_back('{id: 8'd20, last: 1'b1});
    seen = 0;
    for (int c = 0; c < 200 && (rq[0].size() > 0 || exp_rsp[0].size() > 0); c++) begin
      run_cycle();
      if (req_rdy[2]) seen = 1;
    end
    check("hold_rdy2", seen, 0);
    run_until_idle(200);
    check("hold_grants", grant_log.size(), 2);
    check("hold_second", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 64'(2));

    // Lookup engine never answers.
    do_reset();
    set_knobs(100, 100, 0, 0, 0, 0);
    eng_mute = 1;
    rq[1].push_back('{id: 8'd7, last: 1'b1});
    rq[2].push_back('{id: 8'd8, last: 1'b1});
    for (int c = 0; c < 20 && issues == 0; c++) run_cycle();
    n = 0; seen = 0;
    while (n < 2 * TMO) begin
      run_cycle();
      if (rsp_valid != 0) seen = 1;
      if (timeout_err) break;
      n++;
    end
    eng_mute = 0;
    check("tmo_latency", n, TMO);
    check("tmo_no_rsp", seen, 0);
    run_cycle();
    check("tmo_pulse_width", timeout_err, 0);
    run_until_idle(100);
    check("tmo_count", tmo_seen, 1);
    check("tmo_next_grant", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 64'(2));
    check("tmo_rsp_cnt", {rsp_cnt[1][7:0], rsp_cnt[2][7:0]}, 16'h0001);

    // Response back-pressure: data held, no new lookup.
    do_reset();
    set_knobs(100, 100, 0, 0, 1, 1);
    rsp_hold = 1;
    rq[3].push_back('{id: 8'd9, last: 1'b1});
    for (int c = 0; c < 50 && !rsp_valid[3]; c++) run_cycle();
    check("bp_rsp_valid", rsp_valid, 4'b1000);
    v = rsp_node;
    stable = 1; quiet = 1;
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      if (rsp_node !== v || !rsp_valid[3]) stable = 0;
      if (lk_valid) quiet = 0;
    end
    check("bp_stable", stable, 1);
    check("bp_no_lk_valid", quiet, 1);
    rsp_hold = 0;
    run_until_idle(50);
    check("bp_rsp_cnt", rsp_cnt[3], 1);

    // Reset while waiting on the engine.
    set_knobs(100, 100, 0, 30, 30, 0);
    rq[0].push_back('{id: 8'd1, last: 1'b1});
    for (int c = 0; c < 50 && !lk_node_rdy; c++) run_cycle();
    check("wait_reached", lk_node_rdy, 1);
    do_reset();
    set_knobs(100, 100, 0, 0, 2, 0);
    rq[2].push_back('{id: 8'd4, last: 1'b1});
    run_until_idle(50);
    check("post_rst_restart", restarts, 1);
    check("post_rst_rsp", rsp_cnt[2], 1);

    // Randomized traffic against the message-level model.
    do_reset();
    set_knobs(60, 60, 30, 0, 4, 1);
    nfields = 0;
    for (int j = 0; j < NR; j++)
      for (int m = 0; m < 3; m++) begin
        n = $urandom_range(3, 1);
        for (int k = 0; k < n; k++) begin
          rq[j].push_back('{id: 8'($urandom), last: (k == n - 1)});
          nfields++;
        end
      end
    run_until_idle(5000);
    tot = 0;
    for (int j = 0; j < NR; j++) tot += rsp_cnt[j];
    check("rand_rsp_total", tot, nfields);
    check("rand_grants", grant_log.size(), 3 * NR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
